multicycle_alu: RTL and testbench

- Execute-stage ALU directly downstream of ALU_control; consumes its 4-bit operation code plus two register operands.
- AND/OR/ADD/SUB complete in one cycle. MUL and DIV are iterative, one bit per cycle.
- Start/busy/done handshake lets the pipeline controller stall the execute stage while the ALU is busy.

---
 rtl/multicycle_alu_pkg.sv | 20 ++
 rtl/multicycle_alu_if.sv | 22 ++
 rtl/multicycle_alu_muldiv_iter.sv | 101 ++++++++++
 rtl/multicycle_alu.sv | 112 +++++++++++
 tb/tb_multicycle_alu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode and FSM encodings for the execute-stage ALU.
// The opcode values match what ALU_control drives onto ALU_ctl.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b0100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Start/busy/done handshake and operand/result bus between the pipeline
// controller (master) and the ALU (slave).
interface multicycle_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       ALU_ctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALU_ctl, A, B,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, ALU_ctl, A, B,
    output result, zero, busy, done
  );
endinterface

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative one-bit-per-step engine: shift-add multiply and restoring signed
// divide on magnitudes, with the quotient sign fixed up on the way out.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             finished,
  output logic [WIDTH-1:0] res
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // acc: product accumulator for MUL, partial remainder for DIV.
  // opa: shifting multiplicand for MUL, dividend/quotient shifter for DIV.
  // opb: shifting multiplier for MUL, divisor magnitude for DIV.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
    rem_sh = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};

    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;

    if (load) begin
      acc_d    = '0;
      cnt_d    = '0;
      is_div_d = op_is_div;
      if (op_is_div) begin
        opa_d = a_mag;
        opb_d = b_mag;
        neg_d = a[WIDTH-1] ^ b[WIDTH-1];
      end else begin
        opa_d = a;
        opb_d = b;
        neg_d = 1'b0;
      end
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff;
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh;
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (opb_q[0]) acc_d = {1'b0, acc_q[WIDTH-1:0] + opa_q};
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    end
  end

  // The final value is taken from the post-step state so the top can
  // register it on the same edge as the last iteration.
  assign finished = step && (cnt_q == CNT_LAST);
  assign res = is_div_q ? (neg_q ? (~opa_d + 1'b1) : opa_d) : acc_d[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative MUL/DIV,
// start/busy/done handshake toward the pipeline controller.
//
// state   | meaning
// IDLE    | waiting for start; start is only sampled here
// CALC    | MUL/DIV iterating one bit per cycle
// DONE    | done pulse; result/zero valid
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_alu_if.slave   bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load;
  logic             step;
  logic             finished;
  logic [WIDTH-1:0] iter_res;
  logic             upd;
  logic [WIDTH-1:0] new_res;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .op_is_div (bus.ALU_ctl == OP_DIV),
    .a         (bus.A),
    .b         (bus.B),
    .step      (step),
    .finished  (finished),
    .res       (iter_res)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    upd     = 1'b0;
    new_res = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.ALU_ctl)
            OP_AND: begin upd = 1'b1; new_res = bus.A & bus.B; end
            OP_OR:  begin upd = 1'b1; new_res = bus.A | bus.B; end
            OP_ADD: begin upd = 1'b1; new_res = bus.A + bus.B; end
            OP_SUB: begin upd = 1'b1; new_res = bus.A - bus.B; end
            OP_MUL: load = 1'b1;
            OP_DIV: begin
              // RISC-V divide-by-zero returns all ones without iterating.
              if (bus.B == '0) begin
                upd     = 1'b1;
                new_res = '1;
              end else begin
                load = 1'b1;
              end
            end
            default: upd = 1'b1;
          endcase
          state_d = load ? ST_CALC : ST_DONE;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (finished) begin
          upd     = 1'b1;
          new_res = iter_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    result_d = upd ? new_res : result_q;
    zero_d   = upd ? (new_res == '0) : zero_q;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu against a plain-arithmetic reference.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int LONG_LAT = W + 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_alu_if #(.WIDTH(W)) alu_if ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (alu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = W'($signed(a) / $signed(b));
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == OP_MUL || (op == OP_DIV && b != 0)) return LONG_LAT;
    return 1;
  endfunction

  // Drives one request and counts cycles until done (capped at 100).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit toggle, output int lat);
    @(negedge clk);
    alu_if.start   = 1'b1;
    alu_if.ALU_ctl = op;
    alu_if.A       = a;
    alu_if.B       = b;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (!hold) alu_if.start = 1'b0;
      if (toggle) begin
        alu_if.A = $urandom;
        alu_if.B = $urandom;
      end
      if (alu_if.done) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    alu_if.start = 1'b0; alu_if.ALU_ctl = '0; alu_if.A = '0; alu_if.B = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({alu_if.result, alu_if.zero, alu_if.busy, alu_if.done} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got result=%h zero=%b busy=%b done=%b, want 0/1/0/0",
               alu_if.result, alu_if.zero, alu_if.busy, alu_if.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({alu_if.result, alu_if.zero, alu_if.busy, alu_if.done} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_after_reset[%0d]: got result=%h zero=%b busy=%b done=%b", i,
                 alu_if.result, alu_if.zero, alu_if.busy, alu_if.done);
      end
    end
  endtask

  // Directed cases: op, a, b.
  task automatic test_directed;
    logic [3:0]   ops [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_MUL, OP_DIV, OP_DIV, OP_DIV};
    logic [W-1:0] as  [9] = '{32'd5, 32'd9, 32'hF0F0, 32'hF0F0, 32'hFFFF_FFFD, 32'h1_0000,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'd1234};
    logic [W-1:0] bs  [9] = '{32'd7, 32'd9, 32'h0FF0, 32'h0FF0, 32'd7, 32'h1_0000,
                             32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] want [9] = '{32'd12, 32'd0, 32'h00F0, 32'hFFF0, 32'hFFFF_FFEB, 32'd0,
                              32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, 1'b0, lat);
      n_checks++;
      if (alu_if.result !== want[i] || alu_if.zero !== (want[i] == 0)) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h zero=%b, want %h zero=%b", i,
                 alu_if.result, alu_if.zero, want[i], want[i] == 0);
      end
      n_checks++;
      if (lat != model_lat(ops[i], bs[i])) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, model_lat(ops[i], bs[i]));
      end
    end
  endtask

  task automatic test_handshake;
    int lat;
    logic [W-1:0] want;
    want = model(OP_MUL, 32'd123457, 32'hFFFF_FF00);
    run_op(OP_MUL, 32'd123457, 32'hFFFF_FF00, 1'b1, 1'b1, lat);
    n_checks++;
    if (lat != LONG_LAT || alu_if.result !== want) begin
      n_fail++;
      $display("FAIL handshake_mul: got lat=%0d result=%h, want lat=%0d result=%h", lat, alu_if.result, LONG_LAT, want);
    end
    @(negedge clk);
    n_checks++;
    if (alu_if.busy !== 1'b0 || alu_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_idle_gap: got busy=%b done=%b, want 0/0", alu_if.busy, alu_if.done);
    end
    @(negedge clk);
    n_checks++;
    if (alu_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_restart: got busy=%b, want 1", alu_if.busy);
    end
    alu_if.start = 1'b0;
    for (int i = 0; i < 60 && alu_if.busy; i++) @(negedge clk);
    n_checks++;
    if (alu_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_drain: got busy=%b, want 0", alu_if.busy);
    end
  endtask

  task automatic test_reset_mid_div;
    int lat;
    int dones;
    run_op(OP_ADD, 32'd40, 32'd2, 1'b0, 1'b0, lat);
    @(negedge clk);
    alu_if.start = 1'b1; alu_if.ALU_ctl = OP_DIV; alu_if.A = 32'd1000; alu_if.B = 32'd7;
    @(posedge clk);
    dones = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      alu_if.start = 1'b0;
      if (alu_if.done) dones++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (alu_if.busy !== 1'b0 || alu_if.result !== 32'd0 || alu_if.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_div: got busy=%b result=%h zero=%b, want 0/0/1", alu_if.busy, alu_if.result, alu_if.zero);
    end
    repeat (3) begin
      @(negedge clk);
      if (alu_if.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alu_if.done) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_div_no_done: got %0d done pulses, want 0", dones);
    end
    run_op(OP_ADD, 32'd3, 32'd4, 1'b0, 1'b0, lat);
    n_checks++;
    if (alu_if.result !== 32'd7 || lat != 1) begin
      n_fail++;
      $display("FAIL add_after_reset: got result=%h lat=%0d, want 7 lat=1", alu_if.result, lat);
    end
  endtask

  task automatic test_random;
    logic [3:0] op_tab [7] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, 4'b1111};
    logic [3:0]   op;
    logic [W-1:0] a, b, want;
    int lat;
    for (int i = 0; i < 30; i++) begin
      op = op_tab[$urandom_range(0, 6)];
      a = ($urandom_range(0, 3) == 0) ? W'($signed($urandom_range(0, 40)) - 20) : W'($urandom);
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($signed($urandom_range(0, 20)) - 10);
        default: b = W'($urandom);
      endcase
      want = model(op, a, b);
      run_op(op, a, b, 1'b0, 1'b0, lat);
      n_checks++;
      if (alu_if.result !== want || alu_if.zero !== (want == 0) || lat != model_lat(op, b)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got %h zero=%b lat=%0d, want %h zero=%b lat=%0d",
                 i, op, a, b, alu_if.result, alu_if.zero, lat, want, want == 0, model_lat(op, b));
      end
      @(negedge clk);
      n_checks++;
      if (alu_if.done !== 1'b0 || alu_if.result !== want) begin
        n_fail++;
        $display("FAIL random_pulse[%0d]: got done=%b result=%h, want done=0 result=%h", i, alu_if.done, alu_if.result, want);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
